// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: memory req/ack side, instruction valid/ready side,
// and the redirect/halt controls from execute.
interface fetch_queue_if;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, hlt,
    input  mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr,
    output inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, hlt,
    output mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr,
    input  inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: req/ack fetch engine feeding a prefetch FIFO
// of {pc, word}, drained by decode and flushed on redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   fpc_q, fpc_d;
  logic [15:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pc_mem [DEPTH];
  logic [15:0]   word_mem [DEPTH];

  logic push, pop, room, go, cont, issue;

  assign bus.inst_valid = cnt_q != '0;
  assign bus.inst    = bus.inst_valid ? word_mem[rd_q] : '0;
  assign bus.inst_pc = bus.inst_valid ? pc_mem[rd_q] : '0;
  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;

  // redirect overrides any same-cycle push or pop
  assign pop  = bus.inst_valid & bus.inst_ready & ~bus.redirect;
  assign push = (state_q == S_WAIT) & bus.mem_ack & ~bus.redirect;

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign room  = cnt_d < CW'(DEPTH);
  assign go    = ~bus.hlt & ~bus.redirect & room;
  assign cont  = ~bus.hlt & room;
  assign issue = ((state_q == S_IDLE) & go)
               | (push & cont);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (go) state_d = S_WAIT;
      S_WAIT:
        if (bus.redirect)
          state_d = bus.mem_ack ? S_IDLE : S_DISCARD;
        else if (bus.mem_ack)
          state_d = cont ? S_WAIT : S_IDLE;
      S_DISCARD:
        if (bus.mem_ack) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fpc_d  = fpc_q;
    addr_d = addr_q;
    req_d  = state_d != S_IDLE;
    unique case (1'b1)
      bus.redirect: begin
        fpc_d = bus.redirect_pc;
        // an outstanding request keeps its address until acked
        if (state_d == S_IDLE) addr_d = bus.redirect_pc;
      end
      issue: begin
        addr_d = fpc_q;
        fpc_d  = fpc_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q  <= RESET_PC;
      addr_q <= RESET_PC;
      req_q  <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      addr_q <= addr_d;
      req_q  <= req_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (bus.redirect) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= addr_q;
      word_mem[wr_q] <= bus.mem_rdata;
    end
  end
endmodule
